// File: rtl/simplecpu_pkg.sv
// Shared simplecpu definitions: instruction width, instruction-memory depth
// and the program-loader state encoding.
package simplecpu_pkg;

  localparam int unsigned INST_W      = 16;
  localparam int unsigned IMEM_ADDR_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HOLD,
    DONE,
    ERR
  } loader_state_t;

endpackage

// File: rtl/loader_release_timer.sv
// Down-counter that keeps the CPU in reset for DLY cycles after a load.
// expire is registered and is high during the last hold cycle.
module loader_release_timer #(
  parameter int unsigned DLY = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expire
);

  localparam int unsigned CNT_W = 4;

  logic [CNT_W-1:0] cnt;

  // expire is raised together with cnt reaching 1, so HOLD lasts exactly DLY cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      expire <= 1'b0;
    end else if (load) begin
      cnt    <= CNT_W'(DLY);
      expire <= (DLY == 1);
    end else if (cnt != '0) begin
      cnt    <= cnt - CNT_W'(1);
      expire <= (cnt == CNT_W'(2));
    end else begin
      expire <= 1'b0;
    end
  end

endmodule

// File: rtl/imem_stream_loader.sv
// Boot-time program loader: writes a valid/ready word stream into simplecpu
// instruction memory and holds the CPU in reset until the program is in place.
// Optional IMEM_LOADER_CHECKSUM_EN: the s_last beat is a checksum of the written words.
module imem_stream_loader
  import simplecpu_pkg::*;
#(
  parameter int unsigned ADDR_W      = IMEM_ADDR_W,
  parameter int unsigned DATA_W      = INST_W,
  parameter int unsigned RELEASE_DLY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_cnt
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};

  loader_state_t state, next_state;
  logic          beat_c;
  logic          full_c;
  logic          wr_c;
  logic          clr_c;
  logic          tmr_load_c;
  logic          expire;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum;

  // Wrap-around sum of every word actually written in this load
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       sum <= '0;
    else if (clr_c) sum <= '0;
    else if (wr_c)  sum <= sum + s_data;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    wr_c       = 1'b0;
    clr_c      = 1'b0;
    tmr_load_c = 1'b0;
    beat_c     = s_valid && (state == LOAD);
    full_c     = (word_cnt == CAPACITY);
    case (state)
      IDLE, DONE, ERR: begin
        if (start) begin
          next_state = LOAD;
          clr_c      = 1'b1;
        end
      end
      LOAD: begin
        if (beat_c) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          // The checksum beat is compared, never written
          if (s_last) begin
            if (sum == s_data) begin
              next_state = HOLD;
              tmr_load_c = 1'b1;
            end else begin
              next_state = ERR;
            end
          end else if (full_c) begin
            next_state = ERR;
          end else begin
            wr_c = 1'b1;
          end
`else
          if (full_c) begin
            next_state = ERR;
          end else begin
            wr_c = 1'b1;
            if (s_last) begin
              next_state = HOLD;
              tmr_load_c = 1'b1;
            end
          end
`endif
        end
      end
      HOLD: begin
        if (expire) next_state = DONE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Status flags follow the next state so they line up with the state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_ready    <= 1'b0;
      cpu_rst    <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      word_cnt   <= '0;
    end else begin
      s_ready <= (next_state == LOAD);
      cpu_rst <= (next_state != DONE);
      busy    <= (next_state == LOAD) || (next_state == HOLD);
      done    <= (next_state == DONE);
      err     <= (next_state == ERR);
      imem_we <= wr_c;
      if (wr_c) begin
        imem_addr  <= word_cnt[ADDR_W-1:0];
        imem_wdata <= s_data;
      end
      // Overflow beats never write, so the count saturates at CAPACITY
      if (clr_c)     word_cnt <= '0;
      else if (wr_c) word_cnt <= word_cnt + CNT_W'(1);
    end
  end

  loader_release_timer #(
    .DLY (RELEASE_DLY)
  ) u_release_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (tmr_load_c),
    .expire (expire)
  );

endmodule

// File: tb/tb_imem_stream_loader.sv
// Directed bench for imem_stream_loader (ADDR_W=4) with a write scoreboard and
// a model of instruction memory; checksum scenarios run when IMEM_LOADER_CHECKSUM_EN is set.
module tb_imem_stream_loader;

  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 16;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic          s_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_wdata;
  logic          cpu_rst;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW:0]   word_cnt;

  int            checks = 0;
  int            errors = 0;
  int            exp_cnt = 0;
  int            n;
  wr_t           exp_q[$];
  logic [DW-1:0] mem     [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];

  imem_stream_loader #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .RELEASE_DLY (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst    (cpu_rst),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .word_cnt   (word_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Every memory write must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst && imem_we) begin
      wr_t e;
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(imem_addr), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(imem_addr), 32'(e.addr));
        check("wr_data", 32'(imem_wdata), 32'(e.data));
      end
      mem[imem_addr] = imem_wdata;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic last, input bit gap);
    int k = 0;
    bit ck_beat;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    while (!s_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("handshake", 32'(s_ready), 32'd1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    ck_beat = last;
`else
    ck_beat = 1'b0;
`endif
    if (s_ready && !ck_beat && exp_cnt < DEPTH) begin
      exp_q.push_back('{addr: AW'(exp_cnt), data: d});
      ref_mem[exp_cnt] = d;
      exp_cnt++;
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (gap) @(negedge clk);
  endtask

  task automatic wait_release(output int cycles);
    cycles = 0;
    while (cpu_rst && cycles < 30) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < exp_cnt; i++) check(tag, 32'(mem[i]), 32'(ref_mem[i]));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_word_cnt", 32'(word_cnt), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // s_valid in IDLE is not consumed
    s_valid = 1'b1;
    s_data  = 16'hBEEF;
    repeat (2) @(negedge clk);
    check("idle_s_ready", 32'(s_ready), 32'd0);
    check("idle_cpu_rst", 32'(cpu_rst), 32'd1);
    s_valid = 1'b0;

`ifndef IMEM_LOADER_CHECKSUM_EN
    // Three-word program
    pulse_start();
    check("load_busy", 32'(busy), 32'd1);
    check("load_s_ready", 32'(s_ready), 32'd1);
    check("load_word_cnt0", 32'(word_cnt), 32'd0);
    exp_cnt = 0;
    send(16'h0101, 1'b0, 1'b0);
    send(16'h0202, 1'b0, 1'b0);
    send(16'h0303, 1'b1, 1'b0);
    check("hold_busy", 32'(busy), 32'd1);
    check("hold_s_ready", 32'(s_ready), 32'd0);
    check("hold_last_we", 32'(imem_we), 32'd1);
    wait_release(n);
    check("release_dly", 32'(n), 32'd4);
    check("t1_done", 32'(done), 32'd1);
    check("t1_word_cnt", 32'(word_cnt), 32'd3);
    check("t1_mem0", 32'(mem[0]), 32'h0101);
    check("t1_mem1", 32'(mem[1]), 32'h0202);
    check("t1_mem2", 32'(mem[2]), 32'h0303);

    // Restart from DONE, then a full 16-word program with gaps
    pulse_start();
    check("restart_cpu_rst", 32'(cpu_rst), 32'd1);
    check("restart_done", 32'(done), 32'd0);
    check("restart_word_cnt", 32'(word_cnt), 32'd0);
    exp_cnt = 0;
    for (int i = 0; i < 16; i++)
      send((i == 15) ? 16'h2456 : DW'(16'h1000 + i), i == 15, i != 15);
    pulse_start();
    check("hold_start_busy", 32'(busy), 32'd1);
    wait_release(n);
    check("hold_start_ignored_dly", 32'(n), 32'd3);
    check("t2_done", 32'(done), 32'd1);
    check("t2_word_cnt", 32'(word_cnt), 32'd16);
    check("t2_mem15", 32'(mem[15]), 32'h2456);
    check_mem("t2_mem");
`endif

    // Overflow: 17 words without s_last
    pulse_start();
    exp_cnt = 0;
    for (int i = 0; i < 17; i++) send(DW'(16'hA000 + i), 1'b0, 1'b0);
    check("ovf_err", 32'(err), 32'd1);
    check("ovf_s_ready", 32'(s_ready), 32'd0);
    check("ovf_cpu_rst", 32'(cpu_rst), 32'd1);
    check("ovf_word_cnt", 32'(word_cnt), 32'd16);
    repeat (3) @(negedge clk);
    check("ovf_err_hold", 32'(err), 32'd1);
    check("ovf_cpu_rst_hold", 32'(cpu_rst), 32'd1);
    check("ovf_q_empty", 32'(exp_q.size()), 32'd0);
    check_mem("ovf_mem");

    // Reset in the middle of a load, then reload from address 0
    pulse_start();
    exp_cnt = 0;
    send(16'h5555, 1'b0, 1'b0);
    send(16'h6666, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("mid_rst_s_ready", 32'(s_ready), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_we", 32'(imem_we), 32'd0);
    check("mid_rst_addr", 32'(imem_addr), 32'd0);
    check("mid_rst_word_cnt", 32'(word_cnt), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    pulse_start();
    exp_cnt = 0;
    send(16'h0011, 1'b0, 1'b0);
    send(16'h0022, 1'b0, 1'b0);
    send(16'h0033, 1'b1, 1'b0);
    wait_release(n);
    check("reload_dly", 32'(n), 32'd4);
    check("reload_done", 32'(done), 32'd1);
    check("reload_word_cnt", 32'(word_cnt), 32'(exp_cnt));
    check_mem("reload_mem");

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Matching checksum
    pulse_start();
    exp_cnt = 0;
    send(16'h0001, 1'b0, 1'b0);
    send(16'h0002, 1'b0, 1'b0);
    send(16'h0003, 1'b1, 1'b0);
    wait_release(n);
    check("ck_ok_dly", 32'(n), 32'd4);
    check("ck_ok_done", 32'(done), 32'd1);
    check("ck_ok_err", 32'(err), 32'd0);
    check("ck_ok_word_cnt", 32'(word_cnt), 32'd2);
    // Wrong checksum
    pulse_start();
    exp_cnt = 0;
    send(16'h0001, 1'b0, 1'b0);
    send(16'h0002, 1'b0, 1'b0);
    send(16'h0004, 1'b1, 1'b0);
    check("ck_bad_err", 32'(err), 32'd1);
    check("ck_bad_cpu_rst", 32'(cpu_rst), 32'd1);
    check("ck_bad_done", 32'(done), 32'd0);
    check("ck_bad_word_cnt", 32'(word_cnt), 32'd2);
`endif

    repeat (2) @(negedge clk);
    #1;
    check("final_q_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_stream_loader.md
Name: imem_stream_loader

Overview:
- Hardware program loader for simplecpu that fills instruction memory at boot from a 16-bit valid/ready word stream, replacing backdoor array writes.
- Writer side of the instruction-memory interface that simplecpu reads from.
- Holds the CPU in reset while loading, then releases it so execution starts at pc 0 with the new program.

Parameters:
- ADDR_W, 8, instruction-memory address width; capacity is 2**ADDR_W words.
- DATA_W, 16, instruction word width.
- RELEASE_DLY, 4, cycles the CPU stays in reset after the last write; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a load; ignored unless state is IDLE, DONE or ERR.
- s_valid  in  1  stream word valid.
- s_data  in  DATA_W  stream instruction word.
- s_last  in  1  marks the final word of the program, qualified by s_valid.
- s_ready  out  1  loader accepts s_data this cycle.
- imem_we  out  1  instruction-memory write enable.
- imem_addr  out  ADDR_W  instruction-memory write address.
- imem_wdata  out  DATA_W  instruction-memory write data.
- cpu_rst  out  1  active-high reset to simplecpu.
- busy  out  1  high in LOAD and HOLD.
- done  out  1  high in DONE.
- err  out  1  high in ERR.
- word_cnt  out  ADDR_W+1  number of words written in the current or last load.

Behaviour:
- While rst is low: state IDLE, cpu_rst=1, and every other output is 0.
- A mid-load rst aborts immediately; memory contents are then undefined.
- States:
  - IDLE: s_ready=0, cpu_rst=1. start -> LOAD and clears word_cnt.
  - LOAD: s_ready=1, cpu_rst=1.
    - Each s_valid&&s_ready beat registers imem_we=1, imem_addr=word_cnt[ADDR_W-1:0] and imem_wdata=s_data on the next cycle, then increments word_cnt.
    - Write latency is one cycle from the handshake; throughput is one word per cycle.
    - Beat with s_last=1 -> HOLD.
    - Beat when word_cnt==2**ADDR_W (overflow) -> ERR. That word is not written and s_ready drops the next cycle.
    - A program of exactly 2**ADDR_W words whose last beat has s_last=1 is legal.
  - HOLD: s_ready=0, cpu_rst=1; a counter runs RELEASE_DLY cycles, then the state goes to DONE.
  - DONE: cpu_rst=0, done=1. start -> LOAD and reasserts cpu_rst in the same cycle start is sampled.
  - ERR: cpu_rst=1, err=1. Only start or rst leaves ERR; start -> LOAD.
- start in LOAD or HOLD is ignored.
- s_valid outside LOAD is ignored; no beat is consumed.
- imem_we is never high in two states other than the LOAD write-pipeline slot.
- The final write completes in the first HOLD cycle.
- word_cnt saturates at 2**ADDR_W and holds its value in DONE and ERR until the next start.
- Empty program: start followed by a first beat with s_last=1 writes 1 word. Zero-length loads do not exist.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- With the macro defined:
  - The beat carrying s_last is a checksum and is not written to memory.
  - The loader keeps a DATA_W-bit wrap-around sum of all written words.
  - If the sum equals the checksum word: HOLD, then DONE.
  - Otherwise: ERR, with cpu_rst still asserted.
  - word_cnt excludes the checksum beat.
- Without the macro: s_last tags an ordinary program word and no sum logic exists.

Decomposition:
- Shared package simplecpu_pkg holds:
  - typedef loader_state_t {IDLE, LOAD, HOLD, DONE, ERR};
  - constant INST_W=16;
  - constant IMEM_ADDR_W=8.
- One natural sub-module, loader_release_timer: a down-counter for RELEASE_DLY with load and expire outputs.
- The write pipeline and FSM stay in the top module.

Test Plan:
- Reset, then start, then stream 16'h0101, 16'h0202, 16'h0303 with last on the third word -> instmem[0..2] hold those values, word_cnt=3, cpu_rst falls 4 cycles after the last write, done=1.
- Stream with s_valid toggling every other cycle across 16 words ending in 16'h2456 -> no dropped or duplicated words, word_cnt=16, instmem[15]=16'h2456.
- With ADDR_W=4, send 17 words and no s_last -> err=1 after the 17th beat, instmem[0..15] intact, cpu_rst stays 1.
- Assert rst low in the middle of LOAD -> cpu_rst=1 and all other outputs 0 asynchronously; a fresh start then loads correctly from address 0.
- start pulse in HOLD -> ignored; start pulse in DONE -> cpu_rst=1 the next cycle and reload begins at address 0.
- With IMEM_LOADER_CHECKSUM_EN: words 16'h0001, 16'h0002 plus checksum 16'h0003 -> done. Same words with checksum 16'h0004 -> err=1, cpu_rst=1.
